// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmit FSM state type
package uart_pkg;

    localparam int CLKS_PER_TICK = 13;
    localparam int TICKS_PER_BIT = 16;
    localparam int FIFO_ADDR_W   = 9;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_FETCH   = 3'd1,
        TX_WAIT_RD = 3'd2,
        TX_START   = 3'd3,
        TX_DATA    = 3'd4,
        TX_STOP    = 3'd5,
        TX_DONE    = 3'd6
    } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick divider, one tick every CLKS_PER_TICK clocks
module uart_baud_tick #(
    parameter int CLKS_PER_TICK = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] r_clk_cnt;

    // Divider counts only while enabled; held at zero otherwise so a new frame starts phase-aligned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_cnt <= '0;
        end else if (clr || !en) begin
            r_clk_cnt <= '0;
        end else if (r_clk_cnt == CNT_LAST) begin
            r_clk_cnt <= '0;
        end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
        end
    end

    assign tick = en && (r_clk_cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - drains the Tx BRAM FIFO and serializes bytes as 8N1
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int P_CLKS_PER_TICK = CLKS_PER_TICK,
    parameter int P_TICKS_PER_BIT = TICKS_PER_BIT,
    parameter int ADDR_W          = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_start,
    input  logic [ADDR_W:0]   tx_len,
    input  logic [7:0]        tx_fifo_rd,
    output logic [ADDR_W-1:0] tx_fifo_ra,
    output logic              tx_fifo_ren,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx
);

    localparam int TW = (P_TICKS_PER_BIT > 1) ? $clog2(P_TICKS_PER_BIT) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(P_TICKS_PER_BIT - 1);
    localparam logic [ADDR_W:0] MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};

    tx_state_t         r_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_sent;
    logic [ADDR_W-1:0] r_ra;
    logic [7:0]        r_shift;
    logic [2:0]        r_bit_cnt;
    logic [TW-1:0]     r_tick_cnt;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;

    logic              w_tick;
    logic              w_baud_en;
    logic              w_baud_clr;
    logic              w_bit_end;
    logic [ADDR_W:0]   w_len_clamped;
    logic [ADDR_W:0]   w_sent_next;

    assign w_baud_en     = (r_state == TX_START) || (r_state == TX_DATA) || (r_state == TX_STOP);
    assign w_baud_clr    = (r_state == TX_WAIT_RD);
    assign w_bit_end     = w_tick && (r_tick_cnt == TICK_LAST);
    assign w_len_clamped = (tx_len > MAX_LEN) ? MAX_LEN : tx_len;
    assign w_sent_next   = r_sent + (ADDR_W + 1)'(1);

    uart_baud_tick #(
        .CLKS_PER_TICK (P_CLKS_PER_TICK)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .en    (w_baud_en),
        .clr   (w_baud_clr),
        .tick  (w_tick)
    );

    // Ticks within the current bit; restarted before each frame so bit edges land on exact boundaries
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_baud_clr) begin
            r_tick_cnt <= '0;
        end else if (w_baud_en && w_tick) begin
            if (r_tick_cnt == TICK_LAST) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + TW'(1);
            end
        end
    end

    // Frame sequencer: fetch a byte, shift it out LSB-first between start and stop bits, repeat until len sent
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= TX_IDLE;
            r_len     <= '0;
            r_sent    <= '0;
            r_ra      <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (tx_start) begin
                        r_len  <= w_len_clamped;
                        r_sent <= '0;
                        r_ra   <= '0;
                        r_busy <= 1'b1;
                        if (w_len_clamped == '0) begin
                            r_state <= TX_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= TX_FETCH;
                        end
                    end
                end
                TX_FETCH: begin
                    r_state <= TX_WAIT_RD;
                end
                TX_WAIT_RD: begin
                    r_shift   <= tx_fifo_rd;
                    r_bit_cnt <= '0;
                    r_tx      <= 1'b0;
                    r_state   <= TX_START;
                end
                TX_START: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= TX_STOP;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (w_bit_end) begin
                        r_sent <= w_sent_next;
                        r_ra   <= r_ra + ADDR_W'(1);
                        if (w_sent_next == r_len) begin
                            r_state <= TX_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= TX_FETCH;
                        end
                    end
                end
                TX_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= TX_IDLE;
                end
                default: begin
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign tx_fifo_ra  = r_ra;
    assign tx_fifo_ren = (r_state == TX_FETCH);
    assign tx_busy     = r_busy;
    assign tx_done     = r_done;
    assign tx          = r_tx;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench with BRAM model and line receiver model
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       sel;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    logic       start_a, start_b;
    logic [9:0] len_a, len_b;
    logic [7:0] rd_a = 8'h00;
    logic [7:0] rd_b = 8'h00;
    logic [8:0] ra_a, ra_b;
    logic       ren_a, ren_b, busy_a, busy_b, done_a, done_b, tx_a, tx_b;

    logic [7:0] mem [512];

    logic       m_tx, m_ren, m_busy, m_done;
    logic [8:0] m_ra;
    int         mon_bp = 208;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         busy_cyc = 0;
    int         rx_err = 0;
    int         rx_cnt = 0;
    logic       rx_act = 1'b0;
    logic       rx_cur = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    int         ra_log[$];
    int         rx_t[$];
    logic [7:0] rx_q[$];

    uart_tx_serializer dut_a (
        .clk(clk), .reset(reset), .tx_start(start_a), .tx_len(len_a), .tx_fifo_rd(rd_a),
        .tx_fifo_ra(ra_a), .tx_fifo_ren(ren_a), .tx_busy(busy_a), .tx_done(done_a), .tx(tx_a)
    );

    uart_tx_serializer #(.P_CLKS_PER_TICK(1), .P_TICKS_PER_BIT(2)) dut_b (
        .clk(clk), .reset(reset), .tx_start(start_b), .tx_len(len_b), .tx_fifo_rd(rd_b),
        .tx_fifo_ra(ra_b), .tx_fifo_ren(ren_b), .tx_busy(busy_b), .tx_done(done_b), .tx(tx_b)
    );

    always #5 clk = ~clk;

    // Cycle counter used to timestamp observed events
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM models: data valid one clock after ren, garbage on every other cycle
    always @(posedge clk) begin
        rd_a <= ren_a ? mem[ra_a] : 8'($urandom);
        rd_b <= ren_b ? mem[ra_b] : 8'($urandom);
    end

    assign m_tx   = sel ? tx_b   : tx_a;
    assign m_ren  = sel ? ren_b  : ren_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_done = sel ? done_b : done_a;
    assign m_ra   = sel ? ra_b   : ra_a;

    // Line receiver and event logger for the selected DUT, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            rx_act <= 1'b0;
        end else begin
            if (m_ren) ra_log.push_back(int'(m_ra));
            if (m_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (m_busy) busy_cyc <= busy_cyc + 1;
            if (!rx_act) begin
                if (m_tx === 1'b0) begin
                    rx_act <= 1'b1;
                    rx_cnt <= 1;
                    rx_cur <= 1'b0;
                    rx_t.push_back(cyc);
                end
            end else begin
                if (rx_cnt % mon_bp == 0) begin
                    rx_cur <= m_tx;
                    if (rx_cnt / mon_bp <= 8) rx_byte <= {m_tx, rx_byte[7:1]};
                    else if (m_tx !== 1'b1) rx_err <= rx_err + 1;
                end else if (m_tx !== rx_cur) begin
                    rx_err <= rx_err + 1;
                end
                if (rx_cnt == 10 * mon_bp - 1) begin
                    rx_q.push_back(rx_byte);
                    rx_act <= 1'b0;
                end else begin
                    rx_cnt <= rx_cnt + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int c, input logic v, input int l);
        if (c == 0) begin
            start_a = v;
            len_a   = 10'(l);
        end else begin
            start_b = v;
            len_b   = 10'(l);
        end
    endtask

    task automatic run_job(input string name, input int c, input int len_in, input int inj_at, input int inj_len);
        int n, bp, f, k, exp_done, limit, bad;
        int q0, r0, t0, d0, b0, e0;
        bp = (c == 0) ? 208 : 2;
        f  = 10 * bp;
        n  = (len_in > 512) ? 512 : len_in;
        @(negedge clk);
        sel    = (c != 0);
        mon_bp = bp;
        q0 = ra_log.size(); r0 = rx_q.size(); t0 = rx_t.size();
        d0 = done_cnt; b0 = busy_cyc; e0 = rx_err;
        k = cyc;
        drive(c, 1'b1, len_in);
        exp_done = (n == 0) ? k + 1 : k + 3 + n * f + (n - 1) * 2;
        limit    = exp_done - k + 100;
        @(negedge clk);
        drive(c, 1'b0, len_in);
        while (cyc < k + limit && !(done_cnt > d0 && cyc >= done_cyc + 30)) begin
            @(negedge clk);
            if (inj_at > 0 && cyc == k + inj_at) drive(c, 1'b1, inj_len);
            else drive(c, 1'b0, inj_len);
        end
        drive(c, 1'b0, 0);
        chk({name, ".done_count"}, done_cnt - d0, 1);
        chk({name, ".done_cycle"}, done_cyc - k, exp_done - k);
        chk({name, ".busy_cycles"}, busy_cyc - b0, exp_done - k);
        chk({name, ".ren_count"}, ra_log.size() - q0, n);
        bad = 0;
        for (int i = 0; i < n && q0 + i < ra_log.size(); i++)
            if (ra_log[q0 + i] != i % 512) bad++;
        chk({name, ".ra_sequence_errs"}, bad, 0);
        chk({name, ".frame_count"}, rx_q.size() - r0, n);
        bad = 0;
        for (int i = 0; i < n && r0 + i < rx_q.size(); i++)
            if (rx_q[r0 + i] !== mem[i]) bad++;
        chk({name, ".data_errs"}, bad, 0);
        bad = 0;
        for (int i = 0; i < n && t0 + i < rx_t.size(); i++)
            if (rx_t[t0 + i] - k != 3 + i * (f + 2)) bad++;
        chk({name, ".frame_time_errs"}, bad, 0);
        chk({name, ".line_errs"}, rx_err - e0, 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    endtask

    initial begin
        reset = 1'b0; sel = 1'b0;
        start_a = 1'b0; start_b = 1'b0; len_a = '0; len_b = '0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        #1 reset = 1'b1;
        #2;
        chk("rst.tx_a", int'(tx_a), 1);
        chk("rst.busy_a", int'(busy_a), 0);
        chk("rst.ren_a", int'(ren_a), 0);
        chk("rst.done_a", int'(done_a), 0);
        chk("rst.ra_a", int'(ra_a), 0);
        chk("rst.tx_b", int'(tx_b), 1);
        chk("rst.busy_b", int'(busy_b), 0);
        chk("rst.ren_b", int'(ren_b), 0);
        chk("rst.done_b", int'(done_b), 0);
        chk("rst.ra_b", int'(ra_b), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        mem[0] = 8'h55;
        run_job("single_55", 0, 1, 0, 0);

        mem[0] = 8'hA5; mem[1] = 8'h00; mem[2] = 8'hFF;
        run_job("three_bytes", 0, 3, 0, 0);

        run_job("len_zero", 0, 0, 0, 0);

        fill_random();
        run_job("start_mid_frame", 0, 2, 700, 9);
        run_job("start_in_done", 0, 1, 2083, 4);

        @(negedge clk);
        sel = 1'b0;
        drive(0, 1'b1, 3);
        @(negedge clk);
        drive(0, 1'b0, 3);
        repeat (208 * 4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset.tx", int'(tx_a), 1);
        chk("midreset.busy", int'(busy_a), 0);
        chk("midreset.ren", int'(ren_a), 0);
        chk("midreset.done", int'(done_a), 0);
        chk("midreset.ra", int'(ra_a), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        fill_random();
        run_job("post_reset", 0, 2, 0, 0);

        fill_random();
        run_job("fast_len512", 1, 512, 0, 0);
        fill_random();
        run_job("fast_len700", 1, 700, 0, 0);
        fill_random();
        run_job("fast_rand", 1, $urandom_range(1, 60), 5, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
